// File: rtl/axi_up_pkg.sv
// Shared types for the axi_up command queue: descriptor record and issue FSM states.
package axi_up_pkg;

    localparam int ADDR_W = 32;
    localparam int SIZE_W = 15;

    typedef struct packed {
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
        logic [SIZE_W-1:0] size;
    } desc_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    // Zero-length descriptors are retired without waking the copy engine.
    function automatic logic desc_is_null(input desc_t d);
        return (d.size == {SIZE_W{1'b0}});
    endfunction

endpackage

// File: rtl/axi_up_desc_fifo.sv
// Synchronous descriptor FIFO with flush; ready is registered from the next level.
module axi_up_desc_fifo
    import axi_up_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  desc_t            wr_data,
    output desc_t            rd_data,
    output logic             empty,
    output logic             empty_next,
    output logic             ready,
    output logic [LVL_W-1:0] level
);

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic [LVL_W-1:0] level_next_s;
    logic             ready_r;
    logic             full_s;
    logic             do_push_s;
    logic             do_pop_s;
    desc_t            mem_r [DEPTH];

    assign full_s    = (level_r == LVL_W'(DEPTH));
    assign empty     = (level_r == {LVL_W{1'b0}});
    assign do_push_s = push && !full_s && !flush;
    assign do_pop_s  = pop && !empty && !flush;

    // Next occupancy; flush overrides any push/pop in the same cycle.
    always_comb begin
        level_next_s = level_r;
        if (flush) begin
            level_next_s = {LVL_W{1'b0}};
        end else begin
            case ({do_push_s, do_pop_s})
                2'b10:   level_next_s = level_r + LVL_W'(1);
                2'b01:   level_next_s = level_r - LVL_W'(1);
                default: level_next_s = level_r;
            endcase
        end
    end

    // Pointer, level and ready registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
            ready_r  <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr_r <= {PTR_W{1'b0}};
                rd_ptr_r <= {PTR_W{1'b0}};
            end else begin
                if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            level_r <= level_next_s;
            ready_r <= (level_next_s != LVL_W'(DEPTH));
        end
    end

    // Descriptor storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= wr_data;
    end

    assign rd_data    = mem_r[rd_ptr_r];
    assign empty_next = (level_next_s == {LVL_W{1'b0}});
    assign ready      = ready_r;
    assign level      = level_r;

endmodule

// File: rtl/axi_up_cmd_queue.sv
// Descriptor queue in front of the axi_up_ctrl copy engine: buffers copies and
// issues them one at a time over the src/dst/size/trigger/busy handshake.
module axi_up_cmd_queue
    import axi_up_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = ADDR_W,
    parameter int REG_SIZE_WIDTH = SIZE_W,
    parameter int DEPTH          = 8,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0]  push_src_addr_i,
    input  logic [AXI_ADDR_WIDTH-1:0]  push_dst_addr_i,
    input  logic [REG_SIZE_WIDTH-1:0]  push_size_i,
    input  logic                       flush_i,
    input  logic                       int_en_i,
    input  logic                       clr_int_pulse_i,
    output logic [AXI_ADDR_WIDTH-1:0]  src_addr_o,
    output logic [AXI_ADDR_WIDTH-1:0]  dst_addr_o,
    output logic [REG_SIZE_WIDTH-1:0]  size_o,
    output logic                       trigger_pulse_o,
    input  logic                       busy_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       active_o,
    output logic [CNT_WIDTH-1:0]       done_cnt_o,
    output logic                       int_pending_o,
    output logic                       int_o
);

    state_t state_r;
    state_t state_next_s;

    desc_t  wr_desc_s;
    desc_t  head_s;
    logic   fifo_empty_s;
    logic   fifo_empty_next_s;
    logic   fifo_ready_s;
    logic   push_s;
    logic   pop_s;
    logic   latch_s;
    logic   drop_s;
    logic   complete_s;
    logic   done_evt_s;
    logic   int_set_s;

    logic [AXI_ADDR_WIDTH-1:0] src_r;
    logic [AXI_ADDR_WIDTH-1:0] dst_r;
    logic [REG_SIZE_WIDTH-1:0] size_r;
    logic                      trigger_r;
    logic                      active_r;
    logic [CNT_WIDTH-1:0]      done_cnt_r;
    logic                      int_pending_r;

    assign wr_desc_s    = '{src: push_src_addr_i, dst: push_dst_addr_i, size: push_size_i};
    // Ready drops during a flush so the handshake never reports a dropped push as taken.
    assign push_ready_o = fifo_ready_s && !flush_i;
    assign push_s       = push_valid_i && push_ready_o;

    axi_up_desc_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (ACLK),
        .rst_n      (ARESETn),
        .push       (push_s),
        .pop        (pop_s),
        .flush      (flush_i),
        .wr_data    (wr_desc_s),
        .rd_data    (head_s),
        .empty      (fifo_empty_s),
        .empty_next (fifo_empty_next_s),
        .ready      (fifo_ready_s),
        .level      (level_o)
    );

    // Issue FSM next-state and event decode.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        latch_s      = 1'b0;
        drop_s       = 1'b0;
        complete_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s && !busy_i) begin
                    pop_s = 1'b1;
                    if (desc_is_null(head_s)) begin
                        drop_s       = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        latch_s      = 1'b1;
                        state_next_s = ST_ISSUE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_next_s = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (busy_i) begin
                    state_next_s = ST_WAIT_DONE;
                end else begin
                    state_next_s = ST_WAIT_ACK;
                end
            end
            ST_WAIT_DONE: begin
                if (!busy_i) begin
                    complete_s   = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    assign done_evt_s = complete_s || drop_s;
    assign int_set_s  = done_evt_s && fifo_empty_next_s;

    // State register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state_r <= ST_IDLE;
        else          state_r <= state_next_s;
    end

    // Registered engine-facing outputs, completion counter and interrupt flag.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            src_r         <= {AXI_ADDR_WIDTH{1'b0}};
            dst_r         <= {AXI_ADDR_WIDTH{1'b0}};
            size_r        <= {REG_SIZE_WIDTH{1'b0}};
            trigger_r     <= 1'b0;
            active_r      <= 1'b0;
            done_cnt_r    <= {CNT_WIDTH{1'b0}};
            int_pending_r <= 1'b0;
        end else begin
            if (latch_s) begin
                src_r  <= head_s.src;
                dst_r  <= head_s.dst;
                size_r <= head_s.size;
            end
            trigger_r <= latch_s;
            active_r  <= (state_next_s != ST_IDLE);
            if (done_evt_s) done_cnt_r <= done_cnt_r + CNT_WIDTH'(1);
            if (int_set_s)            int_pending_r <= 1'b1;
            else if (clr_int_pulse_i) int_pending_r <= 1'b0;
        end
    end

    assign src_addr_o      = src_r;
    assign dst_addr_o      = dst_r;
    assign size_o          = size_r;
    assign trigger_pulse_o = trigger_r;
    assign active_o        = active_r;
    assign done_cnt_o      = done_cnt_r;
    assign int_pending_o   = int_pending_r;
    assign int_o           = int_pending_r && int_en_i;

endmodule

// File: tb/tb_axi_up_cmd_queue.sv
// Self-checking bench for axi_up_cmd_queue with a behavioural copy-engine model.
module tb_axi_up_cmd_queue;

    localparam int AW = 32;
    localparam int SW = 15;
    localparam int DEPTH = 8;
    localparam int CW = 16;
    localparam int LW = $clog2(DEPTH) + 1;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic          push_valid_i = 1'b0;
    logic          push_ready_o;
    logic [AW-1:0] push_src_addr_i = '0;
    logic [AW-1:0] push_dst_addr_i = '0;
    logic [SW-1:0] push_size_i = '0;
    logic          flush_i = 1'b0;
    logic          int_en_i = 1'b0;
    logic          clr_int_pulse_i = 1'b0;
    logic [AW-1:0] src_addr_o;
    logic [AW-1:0] dst_addr_o;
    logic [SW-1:0] size_o;
    logic          trigger_pulse_o;
    logic          busy_i;
    logic [LW-1:0] level_o;
    logic          active_o;
    logic [CW-1:0] done_cnt_o;
    logic          int_pending_o;
    logic          int_o;

    always #5 ACLK = ~ACLK;

    axi_up_cmd_queue #(
        .AXI_ADDR_WIDTH (AW),
        .REG_SIZE_WIDTH (SW),
        .DEPTH          (DEPTH),
        .CNT_WIDTH      (CW)
    ) dut (
        .ACLK            (ACLK),
        .ARESETn         (ARESETn),
        .push_valid_i    (push_valid_i),
        .push_ready_o    (push_ready_o),
        .push_src_addr_i (push_src_addr_i),
        .push_dst_addr_i (push_dst_addr_i),
        .push_size_i     (push_size_i),
        .flush_i         (flush_i),
        .int_en_i        (int_en_i),
        .clr_int_pulse_i (clr_int_pulse_i),
        .src_addr_o      (src_addr_o),
        .dst_addr_o      (dst_addr_o),
        .size_o          (size_o),
        .trigger_pulse_o (trigger_pulse_o),
        .busy_i          (busy_i),
        .level_o         (level_o),
        .active_o        (active_o),
        .done_cnt_o      (done_cnt_o),
        .int_pending_o   (int_pending_o),
        .int_o           (int_o)
    );

    // Copy engine: busy one cycle after trigger, for 20 cycles; busy_hold forces busy.
    int eng_cnt;
    bit busy_hold = 1'b0;
    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)             eng_cnt <= 0;
        else if (trigger_pulse_o) eng_cnt <= 20;
        else if (eng_cnt != 0)    eng_cnt <= eng_cnt - 1;
    end
    assign busy_i = busy_hold || (eng_cnt != 0);

    typedef struct { logic [AW-1:0] src; logic [AW-1:0] dst; logic [SW-1:0] size; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_trig = -100;
    int trig_cnt = 0;
    int int_rises = 0;
    bit prev_pend = 1'b0;

    always @(posedge ACLK) cyc <= cyc + 1;

    // Trigger monitor: scoreboard order/content and trigger spacing.
    always @(negedge ACLK) begin
        if (trigger_pulse_o) begin
            trig_cnt++;
            checks++;
            if (cyc - last_trig < 4) begin
                errors++;
                $display("FAIL trig_spacing: got %0d cycles, need >= 4", cyc - last_trig);
            end
            last_trig = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_trigger: src=%h dst=%h size=%0d", src_addr_o, dst_addr_o, size_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (src_addr_o !== mon_e.src || dst_addr_o !== mon_e.dst || size_o !== mon_e.size) begin
                    errors++;
                    $display("FAIL trig_desc: got %h/%h/%0d expected %h/%h/%0d",
                             src_addr_o, dst_addr_o, size_o, mon_e.src, mon_e.dst, mon_e.size);
                end
            end
        end
        if (int_pending_o && !prev_pend) int_rises++;
        prev_pend = int_pending_o;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic push_desc(input logic [AW-1:0] s, input logic [AW-1:0] d,
                             input logic [SW-1:0] z, input bit exp_acc);
        push_valid_i    = 1'b1;
        push_src_addr_i = s;
        push_dst_addr_i = d;
        push_size_i     = z;
        check("push_ready", push_ready_o, exp_acc);
        if (exp_acc && z != '0) exp_q.push_back('{s, d, z});
        tick(1);
        push_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt_o != CW'(target) && n < budget) begin
            tick(1);
            n++;
        end
        check("done_cnt", done_cnt_o, target);
    endtask

    task automatic clear_int();
        clr_int_pulse_i = 1'b1;
        tick(1);
        clr_int_pulse_i = 1'b0;
        check("int_cleared", int_pending_o, 1'b0);
    endtask

    typedef struct { logic [AW-1:0] src; logic [AW-1:0] dst; logic [SW-1:0] size; bit en; } vec_t;
    vec_t vecs[5];

    initial begin
        int exp_done = 0;
        int t0;
        int r0;
        int n;
        logic [AW-1:0] exp_src = '0;
        logic [AW-1:0] exp_dst = '0;
        logic [SW-1:0] exp_size = '0;

        vecs[0] = '{32'h1000_0000, 32'h1000_1000, 15'd64,    1'b1};
        vecs[1] = '{32'h2000_0040, 32'h3000_0000, 15'd1,     1'b0};
        vecs[2] = '{32'hFFFF_FFFC, 32'h0000_0004, 15'h7FFF,  1'b1};
        vecs[3] = '{32'hA5A5_0000, 32'h5A5A_0000, 15'd0,     1'b1};
        vecs[4] = '{32'h0000_0000, 32'hDEAD_BEE0, 15'd4096,  1'b0};

        // Reset state
        tick(3);
        check("rst_ready", push_ready_o, 1'b0);
        check("rst_trig", trigger_pulse_o, 1'b0);
        check("rst_level", level_o, 0);
        check("rst_active", active_o, 1'b0);
        check("rst_done", done_cnt_o, 0);
        check("rst_int", {int_pending_o, int_o}, 2'b00);
        check("rst_addr", {src_addr_o, dst_addr_o, size_o}, 0);
        ARESETn = 1'b1;
        tick(1);
        check("ready_after_rst", push_ready_o, 1'b1);

        // Single descriptors from the table
        foreach (vecs[i]) begin
            int_en_i = vecs[i].en;
            t0 = trig_cnt;
            push_desc(vecs[i].src, vecs[i].dst, vecs[i].size, 1'b1);
            exp_done++;
            wait_done(exp_done, 100);
            if (vecs[i].size != '0) begin
                exp_src  = vecs[i].src;
                exp_dst  = vecs[i].dst;
                exp_size = vecs[i].size;
            end
            check("vec_trig_count", trig_cnt - t0, (vecs[i].size != '0) ? 1 : 0);
            check("vec_int_pending", int_pending_o, 1'b1);
            check("vec_int_o", int_o, vecs[i].en);
            check("vec_level", level_o, 0);
            check("vec_active", active_o, 1'b0);
            check("vec_outputs", {src_addr_o, dst_addr_o, size_o}, {exp_src, exp_dst, exp_size});
            clear_int();
        end

        // Fill to full with engine busy, refuse 9th, then drain in order
        busy_hold = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            push_desc(32'h4000_0000 + 32'(i) * 32'h100, 32'h5000_0000 + 32'(i) * 32'h100, SW'(16 + i), 1'b1);
        check("full_level", level_o, DEPTH);
        push_desc(32'h6000_0000, 32'h7000_0000, 15'd8, 1'b0);
        check("full_level_after_refuse", level_o, DEPTH);
        check("full_active", active_o, 1'b0);
        busy_hold = 1'b0;
        exp_done += DEPTH;
        wait_done(exp_done, DEPTH * 30 + 50);
        check("drained", exp_q.size(), 0);
        check("drain_int", int_pending_o, 1'b1);
        clear_int();

        // Size 0 followed by size 16: one trigger, one interrupt
        t0 = trig_cnt;
        r0 = int_rises;
        push_desc(32'h0800_0000, 32'h0900_0000, 15'd0, 1'b1);
        push_desc(32'h0A00_0000, 32'h0B00_0000, 15'd16, 1'b1);
        exp_done += 2;
        wait_done(exp_done, 100);
        tick(2);
        check("z_trig_count", trig_cnt - t0, 1);
        check("z_int_rises", int_rises - r0, 1);
        clear_int();

        // Flush during first transfer of five
        busy_hold = 1'b1;
        for (int i = 0; i < 5; i++)
            push_desc(32'hC000_0000 + 32'(i) * 32'h40, 32'hD000_0000 + 32'(i) * 32'h40, SW'(32 + i), 1'b1);
        t0 = trig_cnt;
        busy_hold = 1'b0;
        n = 0;
        while (trig_cnt == t0 && n < 20) begin tick(1); n++; end
        check("flush_first_trig", trig_cnt - t0, 1);
        tick(3);
        flush_i = 1'b1;
        push_valid_i = 1'b1;
        push_src_addr_i = 32'hBAD0_0000;
        push_size_i = 15'd4;
        #1;
        check("ready_in_flush", push_ready_o, 1'b0);
        exp_q.delete();
        tick(1);
        flush_i = 1'b0;
        push_valid_i = 1'b0;
        check("flush_level", level_o, 0);
        exp_done += 1;
        wait_done(exp_done, 100);
        tick(30);
        check("flush_no_more_trig", trig_cnt - t0, 1);
        check("flush_level_end", level_o, 0);
        check("flush_done_end", done_cnt_o, exp_done);
        clear_int();

        // Clear on the same cycle as set: set wins
        int_en_i = 1'b1;
        push_desc(32'h1111_0000, 32'h2222_0000, 15'd0, 1'b1);
        clr_int_pulse_i = 1'b1;
        tick(1);
        clr_int_pulse_i = 1'b0;
        exp_done++;
        check("set_wins", int_pending_o, 1'b1);
        check("set_wins_int_o", int_o, 1'b1);
        check("set_wins_done", done_cnt_o, exp_done);
        clear_int();

        // Async reset in WAIT_DONE with three queued
        t0 = trig_cnt;
        push_desc(32'h3000_0000, 32'h3100_0000, 15'd32, 1'b1);
        for (int i = 0; i < 3; i++)
            push_desc(32'h3200_0000 + 32'(i), 32'h3300_0000 + 32'(i), 15'd8, 1'b1);
        tick(5);
        check("pre_rst_trig", trig_cnt - t0, 1);
        check("pre_rst_level", level_o, 3);
        check("pre_rst_active", active_o, 1'b1);
        ARESETn = 1'b0;
        #1;
        check("arst_outputs", {src_addr_o, dst_addr_o, size_o, trigger_pulse_o, active_o}, 0);
        check("arst_level", level_o, 0);
        check("arst_done", done_cnt_o, 0);
        check("arst_int", {int_pending_o, int_o, push_ready_o}, 3'b000);
        exp_q.delete();
        tick(2);
        ARESETn = 1'b1;
        t0 = trig_cnt;
        tick(40);
        check("post_rst_no_trig", trig_cnt - t0, 0);
        check("post_rst_state", {level_o, done_cnt_o, active_o}, 0);
        check("post_rst_ready", push_ready_o, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
